// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, clear-FSM state type and write-port priority helper for regfile_mp.
package regfile_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREGS_DEF = 32;
    localparam int MAX_WP = 2;
    typedef enum logic [0:0] {CLEAR = 1'b0, READY = 1'b1} state_e;
    // Highest-index asserted hit wins; -1 when no port hits.
    function automatic int win_port(input logic [MAX_WP-1:0] hit);
        int w;
        w = -1;
        for (int i = 0; i < MAX_WP; i++) if (hit[i]) w = i;
        return w;
    endfunction
endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: decodes NWP write ports into one enable and data word per register, higher port wins.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NWP = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                  en,
    input  logic [NWP-1:0]        we,
    input  logic [NWP*AW-1:0]     waddr,
    input  logic [NWP*XLEN-1:0]   wdata,
    output logic [NREGS-1:0]      reg_we,
    output logic [NREGS*XLEN-1:0] reg_wd
);
    logic [MAX_WP-1:0] hit;
    int w;
    int ws;
    always_comb begin
        reg_we = '0;
        reg_wd = '0;
        hit = '0;
        w = -1;
        ws = 0;
        for (int r = 1; r < NREGS; r++) begin
            hit = '0;
            for (int i = 0; i < NWP; i++) hit[i] = en && we[i] && waddr[i*AW +: AW] == AW'(r);
            w = win_port(hit);
            ws = w < 0 ? 0 : w;
            reg_we[r] = w >= 0;
            reg_wd[r*XLEN +: XLEN] = wdata[ws*XLEN +: XLEN];
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired to zero and post-reset clear FSM; REGFILE_BYPASS_EN enables write-through reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRP = 2,
    parameter int NWP = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                busy,
    input  logic [NWP-1:0]      we,
    input  logic [NWP*AW-1:0]   waddr,
    input  logic [NWP*XLEN-1:0] wdata,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata
);
    state_e state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic [NREGS-1:0] reg_we;
    logic [NREGS*XLEN-1:0] reg_wd;
    logic [AW-1:0] a;
    logic [XLEN-1:0] rd;

    assign busy = state_q == CLEAR;

    regfile_wr_arb #(.XLEN(XLEN), .NREGS(NREGS), .NWP(NWP)) u_arb (
        .en(state_q == READY),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .reg_we(reg_we),
        .reg_wd(reg_wd)
    );

    always_comb begin
        mem_d = mem_q;
        clr_idx_d = clr_idx_q;
        state_d = state_q;
        if (state_q == CLEAR) begin
            mem_d[clr_idx_q] = '0;
            clr_idx_d = clr_idx_q + 1'b1;
            state_d = clr_idx_q == AW'(NREGS - 1) ? READY : CLEAR;
        end
        for (int r = 0; r < NREGS; r++) if (reg_we[r]) mem_d[r] = reg_wd[r*XLEN +: XLEN];
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            state_q <= CLEAR;
            clr_idx_q <= AW'(1);
        end else begin
            state_q <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        rdata = '0;
        a = '0;
        rd = '0;
        for (int j = 0; j < NRP; j++) begin
            a = raddr[j*AW +: AW];
            rd = mem_q[a];
`ifdef REGFILE_BYPASS_EN
            // Later ports overwrite earlier matches so the highest index wins.
            for (int i = 0; i < NWP; i++)
                if (state_q == READY && we[i] && waddr[i*AW +: AW] == a) rd = wdata[i*XLEN +: XLEN];
`endif
            rdata[j*XLEN +: XLEN] = (busy || a == '0) ? '0 : rd;
        end
    end
endmodule
